// File: rtl/barret_rr_sched_1511.sv
`default_nettype none
// ============================================================================
// Module   : barret_rr_sched_1511
// Purpose  : Two-requester round-robin scheduler in front of a shared,
//            pipelined Barrett reduction datapath (modulus 1511). Each
//            accepted 21-bit operand is reduced to its 11-bit residue and
//            returned tagged with the port it came from, in global
//            acceptance order.
// Ports    : clk, rst_n                 clock, async active-low reset
//            req0_valid/data/ready      requester 0 handshake (21-bit data)
//            req1_valid/data/ready      requester 1 handshake (21-bit data)
//            out_valid/data/port/ready  result handshake (11-bit residue)
//            busy                       any pipeline stage occupied
// Revision : 1.0 - initial release
// ============================================================================
module barret_rr_sched_1511 #(
  parameter int Q  = 1511,
  parameter int MU = 2775
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [20:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [20:0] req1_data,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [10:0] out_data,
  output logic        out_port,
  input  logic        out_ready,
  output logic        busy
);

  localparam logic [21:0] c_q1 = 22'(Q);
  localparam logic [21:0] c_q2 = 22'(2 * Q);
  localparam logic [21:0] c_q3 = 22'(3 * Q);
  localparam logic [21:0] c_mu = 22'(MU);

  // Round-robin pointer: port that wins when both request.
  logic        r_prio;

  // Capture stage: operand as accepted from the winning port.
  logic        r_s0_valid;
  logic        r_s0_port;
  logic [20:0] r_s0_a;

  // S1: quotient estimate numerator, operand carried along.
  logic        r_s1_valid;
  logic        r_s1_port;
  logic [20:0] r_s1_a;
  logic [21:0] r_s1_qh;

  // S2: partially reduced remainder, known to lie in [0, 4*Q).
  logic        r_s2_valid;
  logic        r_s2_port;
  logic [21:0] r_s2_r;

  // S3: output register.
  logic        r_out_valid;
  logic        r_out_port;
  logic [10:0] r_out_data;

  logic        w_advance;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_acc;
  logic        w_acc_port;
  logic [20:0] w_acc_data;
  logic [21:0] w_s1_qh;
  logic [21:0] w_s2_t;
  logic [21:0] w_s2_r;
  logic [21:0] w_s3_sub;
  logic [10:0] w_s3_res;

  // The whole pipeline moves as one unit; a full output register that the
  // consumer is not taking freezes every stage and blocks new grants.
  assign w_advance = !r_out_valid || out_ready;

  assign w_grant0 = req0_valid && (!req1_valid || !r_prio);
  assign w_grant1 = req1_valid && (!req0_valid ||  r_prio);

  assign req0_ready = w_grant0 && w_advance;
  assign req1_ready = w_grant1 && w_advance;

  assign w_acc      = req0_ready || req1_ready;
  assign w_acc_port = req1_ready;
  assign w_acc_data = req1_ready ? req1_data : req0_data;

  // (a >> 11) * MU peaks at 1023 * 2775 = 2,838,825, inside 22 bits.
  assign w_s1_qh = ({1'b0, r_s0_a} >> 11) * c_mu;

  // t*Q never exceeds a, so the subtraction cannot wrap.
  assign w_s2_t = r_s1_qh >> 11;
  assign w_s2_r = {1'b0, r_s1_a} - (w_s2_t * c_q1);

  // Final correction: subtract the largest multiple of Q not above r.
  always_comb begin
    w_s3_sub = 22'd0;
    if (r_s2_r >= c_q3) begin
      w_s3_sub = c_q3;
    end else if (r_s2_r >= c_q2) begin
      w_s3_sub = c_q2;
    end else if (r_s2_r >= c_q1) begin
      w_s3_sub = c_q1;
    end
    w_s3_res = 11'(r_s2_r - w_s3_sub);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio      <= 1'b0;
      r_s0_valid  <= 1'b0;
      r_s0_port   <= 1'b0;
      r_s0_a      <= 21'd0;
      r_s1_valid  <= 1'b0;
      r_s1_port   <= 1'b0;
      r_s1_a      <= 21'd0;
      r_s1_qh     <= 22'd0;
      r_s2_valid  <= 1'b0;
      r_s2_port   <= 1'b0;
      r_s2_r      <= 22'd0;
      r_out_valid <= 1'b0;
      r_out_port  <= 1'b0;
      r_out_data  <= 11'd0;
    end else begin
      if (w_acc) begin
        r_prio <= ~w_acc_port;
      end
      if (w_advance) begin
        r_s0_valid  <= w_acc;
        r_s0_port   <= w_acc_port;
        r_s0_a      <= w_acc_data;
        r_s1_valid  <= r_s0_valid;
        r_s1_port   <= r_s0_port;
        r_s1_a      <= r_s0_a;
        r_s1_qh     <= w_s1_qh;
        r_s2_valid  <= r_s1_valid;
        r_s2_port   <= r_s1_port;
        r_s2_r      <= w_s2_r;
        r_out_valid <= r_s2_valid;
        r_out_port  <= r_s2_port;
        r_out_data  <= w_s3_res;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_port  = r_out_port;
  assign busy      = r_s0_valid || r_s1_valid || r_s2_valid || r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_barret_rr_sched_1511.sv
`default_nettype none
// ============================================================================
// Module   : tb_barret_rr_sched_1511
// Purpose  : Directed and constrained-random checks of the round-robin
//            Barrett scheduler: reset values, latency, residues, alternation,
//            stall behaviour, ordering and mid-flight reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_barret_rr_sched_1511;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, out_ready;
  logic [20:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_port, busy;
  logic [10:0] out_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected results in acceptance order: {port, residue}.
  logic [11:0] sb[$];
  logic [11:0] drop;
  logic        a0, a1;

  always #5 clk = ~clk;

  barret_rr_sched_1511 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_port   (out_port),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  function automatic logic [10:0] gold(input logic [20:0] a);
    return 11'(a % 21'd1511);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the output register against the oldest outstanding result.
  task automatic expect_head(input string tag, input bit pop);
    if (sb.size() == 0) begin
      chk({tag, "_extra"}, {31'd0, out_valid}, 32'd0);
    end else begin
      chk({tag, "_vld"},  {31'd0, out_valid}, 32'd1);
      chk({tag, "_port"}, {31'd0, out_port},  {31'd0, sb[0][11]});
      chk({tag, "_data"}, {21'd0, out_data},  {21'd0, sb[0][10:0]});
      if (pop) drop = sb.pop_front();
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 21'd0;
    req1_data  = 21'd0;
    out_ready  = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {21'd0, out_data},  32'd0);
    chk("rst_out_port",  {31'd0, out_port},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    rst_n = 1'b1;
    sb.delete();
  endtask

  function automatic logic [20:0] rand_op();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 21'h1FFFFF;
    if (sel == 1) return 21'd0;
    return 21'($urandom_range(0, 2097151));
  endfunction

  initial begin
    // ---------------- Port 0 back-to-back, latency and throughput
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 21'd0;
    #1;
    chk("t1_rdy0", {31'd0, req0_ready}, 32'd1);
    chk("t1_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();                       // accept 0
    req0_data = 21'd1510;
    tick();                       // accept 1510
    req0_data = 21'd1511;
    tick();                       // accept 1511
    chk("t1_lat_not_yet", {31'd0, out_valid}, 32'd0);
    req0_data = 21'd3022;
    tick();                       // accept 3022, first result visible
    req0_valid = 1'b0;
    chk("t1_r0_vld",  {31'd0, out_valid}, 32'd1);
    chk("t1_r0_data", {21'd0, out_data},  32'd0);
    chk("t1_r0_port", {31'd0, out_port},  32'd0);
    tick();
    chk("t1_r1_vld",  {31'd0, out_valid}, 32'd1);
    chk("t1_r1_data", {21'd0, out_data},  32'd1510);
    tick();
    chk("t1_r2_data", {21'd0, out_data},  32'd0);
    tick();
    chk("t1_r3_vld",  {31'd0, out_valid}, 32'd1);
    chk("t1_r3_data", {21'd0, out_data},  32'd0);
    tick();
    chk("t1_done_vld",  {31'd0, out_valid}, 32'd0);
    chk("t1_done_busy", {31'd0, busy},      32'd0);

    // ---------------- Port 1 extreme and mid-range operands
    req1_valid = 1'b1;
    req1_data  = 21'd2097151;
    tick();
    req1_data  = 21'd1000000;
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    chk("t2_max_data", {21'd0, out_data}, 32'd1394);
    chk("t2_max_port", {31'd0, out_port}, 32'd1);
    tick();
    chk("t2_mid_data", {21'd0, out_data}, 32'd1229);
    chk("t2_mid_port", {31'd0, out_port}, 32'd1);
    tick();
    chk("t2_done_vld", {31'd0, out_valid}, 32'd0);

    // ---------------- Both ports valid: strict alternation starting at 0
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 21'd1600;
    req1_data  = 21'd3100;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      a0 = req0_ready;
      a1 = req1_ready;
      if (i < 8) begin
        chk("t3_rdy0", {31'd0, a0}, (i % 2 == 0) ? 32'd1 : 32'd0);
        chk("t3_rdy1", {31'd0, a1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      end
      if (a0) sb.push_back({1'b0, gold(req0_data)});
      if (a1) sb.push_back({1'b1, gold(req1_data)});
      tick();
      if (a0) req0_data = req0_data + 21'd1;
      if (a1) req1_data = req1_data + 21'd1;
      if (i >= 3 && i <= 10) begin
        chk("t3_alt_port", {31'd0, out_port}, 32'((i - 3) % 2));
        expect_head("t3_out", 1'b1);
      end else begin
        chk("t3_idle_vld", {31'd0, out_valid}, 32'd0);
      end
    end

    // ---------------- Output stall with both ports requesting
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 21'd5000;
    req1_data  = 21'd7000;
    for (int i = 0; i < 4; i++) begin
      #1;
      a0 = req0_ready;
      a1 = req1_ready;
      if (a0) sb.push_back({1'b0, gold(req0_data)});
      if (a1) sb.push_back({1'b1, gold(req1_data)});
      tick();
      if (a0) req0_data = req0_data + 21'd777;
      if (a1) req1_data = req1_data + 21'd777;
    end
    expect_head("t4_first", 1'b0);
    out_ready = 1'b0;
    #1;
    chk("t4_stall_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("t4_stall_rdy1", {31'd0, req1_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_head("t4_hold", 1'b0);
      chk("t4_hold_rdy0", {31'd0, req0_ready}, 32'd0);
      chk("t4_hold_rdy1", {31'd0, req1_ready}, 32'd0);
      chk("t4_hold_busy", {31'd0, busy},       32'd1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    drop = sb.pop_front();        // held result is taken at the next edge
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_head("t4_resume", 1'b1);
    end
    tick();
    chk("t4_drained_vld", {31'd0, out_valid}, 32'd0);
    chk("t4_queue_empty", 32'(sb.size()),     32'd0);

    // ---------------- Random traffic with random backpressure
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (out_valid) expect_head("rnd", 1'b0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_data  = rand_op();
      end
      if (!req1_valid) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_data  = rand_op();
      end
      #1;
      a0 = req0_ready;
      a1 = req1_ready;
      chk("rnd_onehot", {31'd0, a0 & a1}, 32'd0);
      if (out_valid && out_ready && sb.size() > 0) drop = sb.pop_front();
      if (a0) sb.push_back({1'b0, gold(req0_data)});
      if (a1) sb.push_back({1'b1, gold(req1_data)});
      tick();
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) expect_head("rnd_drain", 1'b1);
      tick();
    end
    chk("rnd_all_out", 32'(sb.size()),     32'd0);
    chk("rnd_idle",    {31'd0, busy},      32'd0);

    // ---------------- Reset with operations in flight
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 21'd123;
    for (int i = 0; i < 4; i++) tick();
    req0_valid = 1'b0;
    chk("t6_pre_vld",  {31'd0, out_valid}, 32'd1);
    chk("t6_pre_busy", {31'd0, busy},      32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld",  {31'd0, out_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy},      32'd0);
    chk("t6_rst_data", {21'd0, out_data},  32'd0);
    tick();
    rst_n      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("t6_grant0_rdy0", {31'd0, req0_ready}, 32'd1);
    chk("t6_grant0_rdy1", {31'd0, req1_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
